// File: rtl/exec_mul_seq.sv
// rtl/exec_mul_seq.sv - shift-add 16x16 multiply sequencer on the shared execute ALU (option: EXEC_MUL_ZERO_SKIP_EN)
module exec_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    input  logic [15:0] alu_sum,
    input  logic        alu_cout,
    output logic        alu_own,
    output logic [15:0] aluA_drv,
    output logic [15:0] aluB_drv,
    output logic [2:0]  aluOp_drv,
    output logic        cin_drv,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [15:0] prod_hi,
    output logic [15:0] prod_lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] mcand;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [3:0]  cnt;
    logic        accept;
    logic        zero_op;

    // A request is only taken when not mid-multiply; reset masks it so stall stays low under reset
    assign accept = start && !rst && (state == IDLE || state == DONE);

`ifdef EXEC_MUL_ZERO_SKIP_EN
    assign zero_op = (opA == 16'd0) || (opB == 16'd0);
`else
    assign zero_op = 1'b0;
`endif

    // All outputs are decodes of registered state, except stall which must freeze the pipe in the accept cycle
    assign busy      = (state == RUN);
    assign alu_own   = (state == RUN);
    assign done      = (state == DONE);
    assign stall     = (state == RUN) || accept;
    assign aluA_drv  = hi;
    assign aluB_drv  = lo[0] ? mcand : 16'h0000;
    assign aluOp_drv = 3'b000;
    assign cin_drv   = 1'b0;
    assign prod_hi   = hi;
    assign prod_lo   = lo;

    // Sequencer: load on accept, one add-then-shift-right step per RUN cycle, sixteen steps total
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mcand <= 16'd0;
            hi    <= 16'd0;
            lo    <= 16'd0;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand <= opA;
                        cnt   <= 4'd0;
                        if (zero_op) begin
                            hi    <= 16'd0;
                            lo    <= 16'd0;
                            state <= DONE;
                        end else begin
                            hi    <= 16'd0;
                            lo    <= opB;
                            state <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    {hi, lo} <= {alu_cout, alu_sum, lo[15:1]};
                    cnt      <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_mul_seq.sv
// tb/tb_exec_mul_seq.sv - directed self-checking bench for exec_mul_seq
module tb_exec_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] opA;
    logic [15:0] opB;
    logic [15:0] alu_sum;
    logic        alu_cout;
    logic        alu_own;
    logic [15:0] aluA_drv;
    logic [15:0] aluB_drv;
    logic [2:0]  aluOp_drv;
    logic        cin_drv;
    logic        stall;
    logic        busy;
    logic        done;
    logic [15:0] prod_hi;
    logic [15:0] prod_lo;

    int checks = 0;
    int errors = 0;
    int own_cnt = 0;
    int cout_cnt = 0;

    exec_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opA       (opA),
        .opB       (opB),
        .alu_sum   (alu_sum),
        .alu_cout  (alu_cout),
        .alu_own   (alu_own),
        .aluA_drv  (aluA_drv),
        .aluB_drv  (aluB_drv),
        .aluOp_drv (aluOp_drv),
        .cin_drv   (cin_drv),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .prod_hi   (prod_hi),
        .prod_lo   (prod_lo)
    );

    // Shared execute-stage ALU: combinational 16-bit adder
    assign {alu_cout, alu_sum} = {1'b0, aluA_drv} + {1'b0, aluB_drv} + {16'd0, cin_drv};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count ALU ownership cycles and carry-out events during ownership
    always @(negedge clk) begin
        if (alu_own) own_cnt++;
        if (alu_own && alu_cout) cout_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 start, cycles 1..16 RUN, cycle 17 DONE; returns in cycle 17 with start low
    task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp, input string tag);
        int run_ok;
        opA = a;
        opB = b;
        start = 1'b1;
        #1;
        check({tag, "_stall_c0"}, {31'd0, stall}, 32'd1);
        step();
        start = 1'b0;
        run_ok = 0;
        for (int i = 1; i <= 16; i++) begin
            if (busy && alu_own && stall && !done) run_ok++;
            step();
        end
        check({tag, "_run_cycles"}, run_ok, 32'd16);
        check({tag, "_done_c17"}, {29'd0, done, busy, stall}, 32'b100);
        check({tag, "_product"}, {prod_hi, prod_lo}, exp);
    endtask

    initial begin
        int own0;
        int cout0;
        int run_ok;
        rst = 1'b1;
        start = 1'b0;
        opA = 16'd0;
        opB = 16'd0;
        step();
        step();
        check("reset_outputs",
              {10'd0, alu_own, busy, done, stall, cin_drv, aluOp_drv, prod_hi},
              32'd0);
        check("reset_prod_lo_drv", {prod_lo, aluA_drv | aluB_drv}, 32'd0);

        // reset wins over start
        opA = 16'd3;
        opB = 16'd5;
        start = 1'b1;
        #1;
        check("rst_start_stall", {31'd0, stall}, 32'd0);
        step();
        check("rst_start_idle", {29'd0, busy, done, stall}, 32'd0);
        start = 1'b0;
        rst = 1'b0;
        step();

        do_mul(16'd3, 16'd5, 32'h0000_000F, "basic");
        step();

        cout0 = cout_cnt;
        do_mul(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "maxcarry");
        check("maxcarry_cout_seen", {31'd0, (cout_cnt > cout0)}, 32'd1);
        step();

        // start held high throughout RUN with different operands
        opA = 16'd100;
        opB = 16'd200;
        start = 1'b1;
        step();
        opA = 16'h0012;
        opB = 16'h0034;
        for (int i = 1; i <= 16; i++) step();
        check("busy_first_done", {29'd0, done, busy, stall}, 32'b101);
        check("busy_first_prod", {prod_hi, prod_lo}, 32'd20000);
        step();
        start = 1'b0;
        run_ok = 0;
        for (int i = 18; i <= 33; i++) begin
            if (busy && !done) run_ok++;
            step();
        end
        check("busy_second_run", run_ok, 32'd16);
        check("busy_second_done", {31'd0, done}, 32'd1);
        check("busy_second_prod", {prod_hi, prod_lo}, 32'h0000_03A8);
        step();

        // reset mid-operation
        opA = 16'h1234;
        opB = 16'h0101;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i < 8; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_ctrl", {27'd0, alu_own, busy, done, stall, cin_drv}, 32'd0);
        check("midrst_prod", {prod_hi, prod_lo}, 32'd0);
        check("midrst_drv", {aluA_drv, aluB_drv}, 32'd0);
        step();
        check("midrst_no_done", {31'd0, done}, 32'd0);
        do_mul(16'd7, 16'd9, 32'h0000_003F, "after_rst");
        step();

        // zero operand
        own0 = own_cnt;
`ifdef EXEC_MUL_ZERO_SKIP_EN
        opA = 16'd0;
        opB = 16'hABCD;
        start = 1'b1;
        #1;
        check("zero_stall_c0", {31'd0, stall}, 32'd1);
        step();
        start = 1'b0;
        check("zero_done_c1", {29'd0, done, busy, stall}, 32'b100);
        check("zero_prod", {prod_hi, prod_lo}, 32'd0);
        check("zero_no_own", own_cnt - own0, 32'd0);
`else
        do_mul(16'd0, 16'hABCD, 32'd0, "zero");
        check("zero_own_cycles", own_cnt - own0, 32'd16);
`endif
        step();

        // hold after done
        do_mul(16'h0100, 16'h0100, 32'h0001_0000, "hold");
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_stable", {done, busy, stall, 13'd0, prod_hi ^ prod_lo}, 32'h0000_0001);
        end
        check("hold_final", {prod_hi, prod_lo}, 32'h0001_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
